conv2_window_buf: RTL and testbench

Streaming 3×3 window generator for the second convolution layer. It accepts three channels of first-layer pooled feature maps in raster order, one pixel per channel per accepted cycle. For every valid 3×3 position it presents 27 signed window taps (9 per channel) together with a one-cycle `valid_out_buf` strobe. It is the producer side of the conv2 channel calculators: its taps connect one-to-one to their `data_outC_K` inputs.

---
 rtl/conv2_pkg.sv | 19 +
 rtl/conv2_line_shift.sv | 22 ++
 rtl/conv2_window_buf.sv | 87 ++++++++
 tb/tb_conv2_window_buf.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/conv2_pkg.sv
// Shared constants and types for the conv2 stage: pixel width, feature-map geometry,
// window-line depth and the per-channel tap-vector type.
package conv2_pkg;
  localparam int DW        = 12;
  localparam int WIDTH     = 12;
  localparam int HEIGHT    = 12;
  localparam int TAP_DEPTH = 2*WIDTH + 3;
  localparam int NUM_CH    = 3;
  localparam int NUM_TAPS  = 9;
  localparam int COL_W     = $clog2(WIDTH);
  localparam int ROW_W     = $clog2(HEIGHT);

  typedef logic [NUM_TAPS-1:0][DW-1:0] win_t;

  // Line position of tap k (row k/3, col k%3) counted back from the newest pixel.
  function automatic int tap_idx(input int k);
    return (2 - k/3)*WIDTH + (2 - k%3);
  endfunction
endpackage

// File: rtl/conv2_line_shift.sv
// One channel's 2*WIDTH+3 pixel line; the nine 3x3 taps come straight off its flops.
module conv2_line_shift
  import conv2_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [DW-1:0] din,
  output win_t          taps
);
  logic [TAP_DEPTH-1:0][DW-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  sr <= '0;
    else if (en) sr <= {sr[TAP_DEPTH-2:0], din};
  end

  // sr[0] holds the most recently accepted pixel, so entry 2*WIDTH+2 is the window's top-left.
  for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
    assign taps[k] = sr[tap_idx(k)];
  end
endmodule

// File: rtl/conv2_window_buf.sv
// Streaming 3x3 window generator for three channels: raster counters, window-valid
// decode and per-channel line shifters whose flops drive the taps directly.
module conv2_window_buf
  import conv2_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_in,
  input  logic signed [DW-1:0] data_in1,
  input  logic signed [DW-1:0] data_in2,
  input  logic signed [DW-1:0] data_in3,
  output logic signed [DW-1:0] data_out1_0, data_out1_1, data_out1_2,
  output logic signed [DW-1:0] data_out1_3, data_out1_4, data_out1_5,
  output logic signed [DW-1:0] data_out1_6, data_out1_7, data_out1_8,
  output logic signed [DW-1:0] data_out2_0, data_out2_1, data_out2_2,
  output logic signed [DW-1:0] data_out2_3, data_out2_4, data_out2_5,
  output logic signed [DW-1:0] data_out2_6, data_out2_7, data_out2_8,
  output logic signed [DW-1:0] data_out3_0, data_out3_1, data_out3_2,
  output logic signed [DW-1:0] data_out3_3, data_out3_4, data_out3_5,
  output logic signed [DW-1:0] data_out3_6, data_out3_7, data_out3_8,
  output logic                 valid_out_buf
);
  logic [COL_W-1:0]                 col;
  logic [ROW_W-1:0]                 row;
  logic                             win_hit;
  logic [NUM_CH-1:0][DW-1:0]        din;
  logic [NUM_CH-1:0][NUM_TAPS-1:0][DW-1:0] taps;

  assign din     = {data_in3, data_in2, data_in1};
  assign win_hit = valid_in && (row >= ROW_W'(2)) && (col >= COL_W'(2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col           <= '0;
      row           <= '0;
      valid_out_buf <= 1'b0;
    end else begin
      valid_out_buf <= win_hit;
      if (valid_in) begin
        if (col == COL_W'(WIDTH-1)) begin
          col <= '0;
          row <= (row == ROW_W'(HEIGHT-1)) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    conv2_line_shift u_line (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (valid_in),
      .din  (din[ch]),
      .taps (taps[ch])
    );
  end

  assign data_out1_0 = taps[0][0];
  assign data_out1_1 = taps[0][1];
  assign data_out1_2 = taps[0][2];
  assign data_out1_3 = taps[0][3];
  assign data_out1_4 = taps[0][4];
  assign data_out1_5 = taps[0][5];
  assign data_out1_6 = taps[0][6];
  assign data_out1_7 = taps[0][7];
  assign data_out1_8 = taps[0][8];
  assign data_out2_0 = taps[1][0];
  assign data_out2_1 = taps[1][1];
  assign data_out2_2 = taps[1][2];
  assign data_out2_3 = taps[1][3];
  assign data_out2_4 = taps[1][4];
  assign data_out2_5 = taps[1][5];
  assign data_out2_6 = taps[1][6];
  assign data_out2_7 = taps[1][7];
  assign data_out2_8 = taps[1][8];
  assign data_out3_0 = taps[2][0];
  assign data_out3_1 = taps[2][1];
  assign data_out3_2 = taps[2][2];
  assign data_out3_3 = taps[2][3];
  assign data_out3_4 = taps[2][4];
  assign data_out3_5 = taps[2][5];
  assign data_out3_6 = taps[2][6];
  assign data_out3_7 = taps[2][7];
  assign data_out3_8 = taps[2][8];
endmodule

// File: tb/tb_conv2_window_buf.sv
// Directed bench for conv2_window_buf: windows are predicted from a frame image
// when each pixel is driven and popped/compared on every strobe.
module tb_conv2_window_buf;
  import conv2_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic valid_in = 1'b0;
  logic signed [DW-1:0] data_in1 = '0, data_in2 = '0, data_in3 = '0;
  logic signed [DW-1:0] data_out1_0, data_out1_1, data_out1_2, data_out1_3, data_out1_4,
                        data_out1_5, data_out1_6, data_out1_7, data_out1_8;
  logic signed [DW-1:0] data_out2_0, data_out2_1, data_out2_2, data_out2_3, data_out2_4,
                        data_out2_5, data_out2_6, data_out2_7, data_out2_8;
  logic signed [DW-1:0] data_out3_0, data_out3_1, data_out3_2, data_out3_3, data_out3_4,
                        data_out3_5, data_out3_6, data_out3_7, data_out3_8;
  logic valid_out_buf;

  typedef logic [2:0][8:0][DW-1:0] exp_t;
  exp_t got;
  exp_t q[$];
  int   n_assert = 0, n_fail = 0, n_strobe = 0, n0;
  bit   exp_strobe = 1'b0;
  int   img [3][HEIGHT][WIDTH];

  always #5 clk = ~clk;

  conv2_window_buf dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in),
    .data_in1(data_in1), .data_in2(data_in2), .data_in3(data_in3),
    .data_out1_0(data_out1_0), .data_out1_1(data_out1_1), .data_out1_2(data_out1_2),
    .data_out1_3(data_out1_3), .data_out1_4(data_out1_4), .data_out1_5(data_out1_5),
    .data_out1_6(data_out1_6), .data_out1_7(data_out1_7), .data_out1_8(data_out1_8),
    .data_out2_0(data_out2_0), .data_out2_1(data_out2_1), .data_out2_2(data_out2_2),
    .data_out2_3(data_out2_3), .data_out2_4(data_out2_4), .data_out2_5(data_out2_5),
    .data_out2_6(data_out2_6), .data_out2_7(data_out2_7), .data_out2_8(data_out2_8),
    .data_out3_0(data_out3_0), .data_out3_1(data_out3_1), .data_out3_2(data_out3_2),
    .data_out3_3(data_out3_3), .data_out3_4(data_out3_4), .data_out3_5(data_out3_5),
    .data_out3_6(data_out3_6), .data_out3_7(data_out3_7), .data_out3_8(data_out3_8),
    .valid_out_buf(valid_out_buf)
  );

  assign got[0] = {data_out1_8, data_out1_7, data_out1_6, data_out1_5, data_out1_4,
                   data_out1_3, data_out1_2, data_out1_1, data_out1_0};
  assign got[1] = {data_out2_8, data_out2_7, data_out2_6, data_out2_5, data_out2_4,
                   data_out2_3, data_out2_2, data_out2_1, data_out2_0};
  assign got[2] = {data_out3_8, data_out3_7, data_out3_6, data_out3_5, data_out3_4,
                   data_out3_3, data_out3_2, data_out3_1, data_out3_0};

  // Strobe must match the prediction every cycle; each strobe consumes one window.
  always @(negedge clk) begin
    exp_t w;
    n_assert++;
    assert (valid_out_buf === exp_strobe) else begin
      n_fail++;
      $error("FAIL strobe observed=%0b expected=%0b", valid_out_buf, exp_strobe);
    end
    if (valid_out_buf === 1'b1) begin
      n_strobe++;
      n_assert++;
      assert (q.size() > 0) else begin
        n_fail++;
        $error("FAIL extra_strobe observed=%0d queued expected=1", q.size());
      end
      if (q.size() > 0) begin
        w = q.pop_front();
        for (int ch = 0; ch < 3; ch++) begin
          n_assert++;
          assert (got[ch] === w[ch]) else begin
            n_fail++;
            $error("FAIL taps_ch%0d observed=%h expected=%h", ch+1, got[ch], w[ch]);
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    valid_in = 1'b0;
    data_in1 = DW'($urandom);
    data_in2 = DW'($urandom);
    data_in3 = DW'($urandom);
    @(posedge clk); #1;
    exp_strobe = 1'b0;
  endtask

  // mode 0: ramp (ch1 offset by off), mode 1: signed extremes. Stops after raster index stop.
  task automatic run_frame(input int mode, input int off, input bit gaps, input int stop);
    int   v[3];
    exp_t w;
    bit   win;
    for (int r = 0; r < HEIGHT; r++) begin
      for (int c = 0; c < WIDTH; c++) begin
        if (r*WIDTH + c > stop) return;
        if (gaps)
          for (int g = 0; g < 8 && $urandom_range(1, 0) == 1; g++) idle();
        if (mode == 0) begin
          v[0] = r*WIDTH + c + off;
          v[1] = -(r*WIDTH + c);
          v[2] = r*WIDTH + c + 512;
        end else begin
          v[0] = -2048;
          v[1] = r*WIDTH + c;
          v[2] = 2047;
        end
        for (int ch = 0; ch < 3; ch++) img[ch][r][c] = v[ch];
        win = (r >= 2) && (c >= 2);
        if (win) begin
          for (int ch = 0; ch < 3; ch++)
            for (int k = 0; k < 9; k++) begin
              int t;
              t = img[ch][r-2+k/3][c-2+k%3];
              w[ch][k] = t[DW-1:0];
            end
          q.push_back(w);
        end
        data_in1 = v[0][DW-1:0];
        data_in2 = v[1][DW-1:0];
        data_in3 = v[2][DW-1:0];
        valid_in = 1'b1;
        @(posedge clk); #1;
        exp_strobe = win;
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ch1", got[0], 0);
    chk("reset_ch2", got[1], 0);
    chk("reset_ch3", got[2], 0);
    chk("reset_valid", valid_out_buf, 0);
    rst_n = 1'b1;

    n0 = n_strobe;
    run_frame(0, 0, 1'b0, WIDTH*HEIGHT-1);
    idle();
    chk("ramp_count", n_strobe - n0, 100);
    chk("ramp_last_tap0", {116'b0, data_out1_0}, 117);
    chk("ramp_last_tap8", {116'b0, data_out1_8}, 143);
    chk("ramp_last_ch2_tap8", {116'b0, data_out2_8}, 128'hF71);

    n0 = n_strobe;
    run_frame(0, 0, 1'b1, WIDTH*HEIGHT-1);
    idle();
    chk("gaps_count", n_strobe - n0, 100);

    n0 = n_strobe;
    run_frame(0, 0, 1'b0, WIDTH*HEIGHT-1);
    run_frame(0, 1000, 1'b0, WIDTH*HEIGHT-1);
    idle();
    chk("b2b_count", n_strobe - n0, 200);
    chk("b2b_last_tap0", {116'b0, data_out1_0}, 1117);

    run_frame(0, 0, 1'b0, 5*WIDTH + 7);
    @(negedge clk); #2;
    valid_in = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_ch1", got[0], 0);
    chk("midrst_ch2", got[1], 0);
    chk("midrst_ch3", got[2], 0);
    chk("midrst_valid", valid_out_buf, 0);
    idle();
    idle();
    chk("midrst_queue", q.size(), 0);
    rst_n = 1'b1;
    n0 = n_strobe;
    run_frame(0, 0, 1'b0, WIDTH*HEIGHT-1);
    idle();
    chk("postrst_count", n_strobe - n0, 100);

    n0 = n_strobe;
    run_frame(1, 0, 1'b1, WIDTH*HEIGHT-1);
    idle();
    chk("ext_count", n_strobe - n0, 100);
    chk("ext_ch1_tap0", {116'b0, data_out1_0}, 128'h800);
    chk("ext_ch3_tap8", {116'b0, data_out3_8}, 128'h7FF);

    idle();
    idle();
    chk("final_queue", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
